// File: rtl/gb_apu_pkg.sv
// Shared definitions for the APU pulse-channel register front end:
// register indices, readback OR masks and the NR14 trigger bit position.
package gb_apu_pkg;

    typedef enum logic [2:0] {
        REG_NR10 = 3'd0,
        REG_NR11 = 3'd1,
        REG_NR12 = 3'd2,
        REG_NR13 = 3'd3,
        REG_NR14 = 3'd4
    } reg_idx_e;

    // Bits forced to 1 on readback (unused or write-only bits)
    localparam logic [7:0] NR10_RD_MASK = 8'h80;
    localparam logic [7:0] NR11_RD_MASK = 8'h3F;
    localparam logic [7:0] NR12_RD_MASK = 8'h00;
    localparam logic [7:0] NR13_RD_MASK = 8'hFF;
    localparam logic [7:0] NR14_RD_MASK = 8'hBF;

    localparam int NR14_TRIGGER_BIT = 7;

endpackage

// File: rtl/gb_apu_pulse_regs.sv
// CPU-side NR10..NR14 register block for one pulse channel: write decode,
// trigger pulse, sweep frequency write-back and masked registered readback.
module gb_apu_pulse_regs
    import gb_apu_pkg::*;
#(
    parameter bit HAS_SWEEP = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        apu_enable,
    input  logic [2:0]  addr,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    input  logic        freq_wb_valid,
    input  logic [10:0] freq_wb,
    output logic [2:0]  sweep_time,
    output logic        sweep_decreasing,
    output logic [2:0]  num_sweep_shifts,
    output logic [1:0]  wave_duty,
    output logic [5:0]  length,
    output logic [3:0]  initial_volume,
    output logic        envelope_increasing,
    output logic [2:0]  num_envelope_sweeps,
    output logic [10:0] frequency,
    output logic        single,
    output logic        start,
    output logic        dac_enable
);

    logic [6:0]  nr10_q, nr10_d;
    logic [7:0]  nr11_q, nr11_d;
    logic [7:0]  nr12_q, nr12_d;
    logic [10:0] freq_q, freq_d;
    logic        single_q, single_d;
    logic        dac_q, dac_d;
    logic        start_q, start_d;
    logic [7:0]  rdata_q, rd_mux;

    // Write decode. freq_wb_valid has no ready: it is always taken while
    // powered; a same-cycle CPU write to NR13/NR14 overrides only its own bits.
    always_comb begin
        nr10_d   = nr10_q;
        nr11_d   = nr11_q;
        nr12_d   = nr12_q;
        freq_d   = freq_q;
        single_d = single_q;
        start_d  = 1'b0;
        if (!apu_enable) begin
            nr10_d   = '0;
            nr11_d   = '0;
            nr12_d   = '0;
            freq_d   = '0;
            single_d = 1'b0;
        end else begin
            if (freq_wb_valid) begin
                freq_d = freq_wb;
            end
            if (wr_en) begin
                case (addr)
                    REG_NR10: if (HAS_SWEEP) nr10_d = wdata[6:0];
                    REG_NR11: nr11_d = wdata;
                    REG_NR12: nr12_d = wdata;
                    REG_NR13: freq_d[7:0] = wdata;
                    REG_NR14: begin
                        freq_d[10:8] = wdata[2:0];
                        single_d     = wdata[6];
                        start_d      = wdata[NR14_TRIGGER_BIT];
                    end
                    default: ;
                endcase
            end
        end
        dac_d = |nr12_d[7:3];
    end

    always_comb begin
        rd_mux = 8'hFF;
        case (addr)
            REG_NR10: rd_mux = HAS_SWEEP ? ({1'b0, nr10_q} | NR10_RD_MASK) : 8'hFF;
            REG_NR11: rd_mux = nr11_q | NR11_RD_MASK;
            REG_NR12: rd_mux = nr12_q | NR12_RD_MASK;
            REG_NR13: rd_mux = NR13_RD_MASK;
            REG_NR14: rd_mux = {1'b0, single_q, 6'b0} | NR14_RD_MASK;
            default:  rd_mux = 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nr10_q   <= '0;
            nr11_q   <= '0;
            nr12_q   <= '0;
            freq_q   <= '0;
            single_q <= 1'b0;
            dac_q    <= 1'b0;
            start_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            nr10_q   <= nr10_d;
            nr11_q   <= nr11_d;
            nr12_q   <= nr12_d;
            freq_q   <= freq_d;
            single_q <= single_d;
            dac_q    <= dac_d;
            start_q  <= start_d;
            if (rd_en) begin
                rdata_q <= rd_mux;
            end
        end
    end

    assign sweep_time          = HAS_SWEEP ? nr10_q[6:4] : 3'd0;
    assign sweep_decreasing    = HAS_SWEEP ? nr10_q[3]   : 1'b0;
    assign num_sweep_shifts    = HAS_SWEEP ? nr10_q[2:0] : 3'd0;
    assign wave_duty           = nr11_q[7:6];
    assign length              = nr11_q[5:0];
    assign initial_volume      = nr12_q[7:4];
    assign envelope_increasing = nr12_q[3];
    assign num_envelope_sweeps = nr12_q[2:0];
    assign frequency           = freq_q;
    assign single              = single_q;
    assign start               = start_q;
    assign dac_enable          = dac_q;
    assign rdata               = rdata_q;

endmodule

// File: tb/tb_gb_apu_pulse_regs.sv
// Directed bench for gb_apu_pulse_regs: one instance with sweep (channel 1)
// and one without (channel 2), both driven by the same bus stimulus.
module tb_gb_apu_pulse_regs;

    logic        clk = 1'b0;
    logic        reset;
    logic        apu_enable;
    logic [2:0]  addr;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  wdata;
    logic        freq_wb_valid;
    logic [10:0] freq_wb;

    logic [7:0]  c1_rdata, c2_rdata;
    logic [2:0]  c1_sweep_time, c2_sweep_time;
    logic        c1_sweep_dec, c2_sweep_dec;
    logic [2:0]  c1_shifts, c2_shifts;
    logic [1:0]  c1_duty, c2_duty;
    logic [5:0]  c1_length, c2_length;
    logic [3:0]  c1_vol, c2_vol;
    logic        c1_env_inc, c2_env_inc;
    logic [2:0]  c1_env_n, c2_env_n;
    logic [10:0] c1_freq, c2_freq;
    logic        c1_single, c2_single;
    logic        c1_start, c2_start;
    logic        c1_dac, c2_dac;

    int n_total = 0;
    int n_bad   = 0;

    gb_apu_pulse_regs #(.HAS_SWEEP(1'b1)) u_ch1 (
        .clk(clk), .reset(reset), .apu_enable(apu_enable), .addr(addr),
        .wr_en(wr_en), .rd_en(rd_en), .wdata(wdata), .rdata(c1_rdata),
        .freq_wb_valid(freq_wb_valid), .freq_wb(freq_wb),
        .sweep_time(c1_sweep_time), .sweep_decreasing(c1_sweep_dec),
        .num_sweep_shifts(c1_shifts), .wave_duty(c1_duty), .length(c1_length),
        .initial_volume(c1_vol), .envelope_increasing(c1_env_inc),
        .num_envelope_sweeps(c1_env_n), .frequency(c1_freq), .single(c1_single),
        .start(c1_start), .dac_enable(c1_dac)
    );

    gb_apu_pulse_regs #(.HAS_SWEEP(1'b0)) u_ch2 (
        .clk(clk), .reset(reset), .apu_enable(apu_enable), .addr(addr),
        .wr_en(wr_en), .rd_en(rd_en), .wdata(wdata), .rdata(c2_rdata),
        .freq_wb_valid(freq_wb_valid), .freq_wb(freq_wb),
        .sweep_time(c2_sweep_time), .sweep_decreasing(c2_sweep_dec),
        .num_sweep_shifts(c2_shifts), .wave_duty(c2_duty), .length(c2_length),
        .initial_volume(c2_vol), .envelope_increasing(c2_env_inc),
        .num_envelope_sweeps(c2_env_n), .frequency(c2_freq), .single(c2_single),
        .start(c2_start), .dac_enable(c2_dac)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Driver tasks: outputs are sampled 1 time unit after the capturing edge
    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a);
        addr  = a;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; apu_enable = 1'b0; addr = '0; wr_en = 1'b0; rd_en = 1'b0;
        wdata = '0; freq_wb_valid = 1'b0; freq_wb = '0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_fields", 16'({c1_sweep_time, c1_sweep_dec, c1_shifts, c1_duty, c1_length}), 16'h0);
        check("rst_nr12", 16'({c1_vol, c1_env_inc, c1_env_n}), 16'h0);
        check("rst_freq", 16'(c1_freq), 16'h0);
        check("rst_ctl", 16'({c1_single, c1_start, c1_dac}), 16'h0);
        check("rst_rdata", 16'(c1_rdata), 16'h0);

        apu_enable = 1'b1;
        bus_read(3'd1);
        check("rd_nr11_rst", 16'(c1_rdata), 16'h3F);
        tick();
        check("rdata_hold", 16'(c1_rdata), 16'h3F);

        bus_write(3'd1, 8'h81);
        check("nr11_duty", 16'(c1_duty), 16'h2);
        check("nr11_len", 16'(c1_length), 16'h01);
        bus_read(3'd1);
        check("rd_nr11", 16'(c1_rdata), 16'hBF);

        bus_write(3'd3, 8'hFF);
        bus_write(3'd4, 8'hC7);
        check("trig_start", 16'(c1_start), 16'h1);
        check("trig_freq", 16'(c1_freq), 16'h7FF);
        check("trig_single", 16'(c1_single), 16'h1);
        tick();
        check("start_one_cycle", 16'(c1_start), 16'h0);
        bus_read(3'd4);
        check("rd_nr14", 16'(c1_rdata), 16'hFF);
        bus_read(3'd3);
        check("rd_nr13", 16'(c1_rdata), 16'hFF);

        bus_write(3'd2, 8'h17);
        check("dac_on", 16'(c1_dac), 16'h1);
        check("nr12_fields", 16'({c1_vol, c1_env_inc, c1_env_n}), 16'h17);
        bus_write(3'd2, 8'h07);
        check("dac_off", 16'(c1_dac), 16'h0);
        check("dac_off_freq", 16'(c1_freq), 16'h7FF);
        bus_write(3'd2, 8'h08);
        check("dac_env_bit", 16'(c1_dac), 16'h1);
        check("env_inc", 16'(c1_env_inc), 16'h1);
        bus_read(3'd2);
        check("rd_nr12", 16'(c1_rdata), 16'h08);

        // Sweep write-back alongside CPU writes
        freq_wb_valid = 1'b1; freq_wb = 11'h123;
        bus_write(3'd3, 8'hAA);
        check("wb_nr13", 16'(c1_freq), 16'h1AA);
        tick();
        check("wb_alone", 16'(c1_freq), 16'h123);
        freq_wb = 11'h055;
        bus_write(3'd4, 8'h02);
        freq_wb_valid = 1'b0;
        check("wb_nr14", 16'(c1_freq), 16'h255);
        check("wb_nr14_nostart", 16'({c1_start, c1_single}), 16'h0);

        bus_write(3'd0, 8'h2B);
        check("nr10_ch1", 16'({c1_sweep_time, c1_sweep_dec, c1_shifts}), 16'h2B);
        check("nr10_ch2", 16'({c2_sweep_time, c2_sweep_dec, c2_shifts}), 16'h0);
        bus_read(3'd0);
        check("rd_nr10_ch1", 16'(c1_rdata), 16'hAB);
        check("rd_nr10_ch2", 16'(c2_rdata), 16'hFF);

        bus_write(3'd5, 8'h00);
        check("unmapped_wr", 16'({c1_duty, c1_length}), 16'h81);
        bus_read(3'd6);
        check("rd_unmapped", 16'(c1_rdata), 16'hFF);

        // Read and write of NR11 in the same cycle returns the old value
        rd_en = 1'b1;
        bus_write(3'd1, 8'h40);
        rd_en = 1'b0;
        check("rd_wr_same", 16'(c1_rdata), 16'hBF);
        check("rd_wr_newduty", 16'(c1_duty), 16'h1);

        // Back-to-back triggers
        addr = 3'd4; wdata = 8'h80; wr_en = 1'b1;
        tick();
        check("b2b_start1", 16'(c1_start), 16'h1);
        tick();
        check("b2b_start2", 16'(c1_start), 16'h1);
        wr_en = 1'b0;
        tick();
        check("b2b_end", 16'(c1_start), 16'h0);

        // Power off
        apu_enable = 1'b0;
        tick();
        check("off_fields", 16'({c1_duty, c1_length, c1_sweep_time, c1_shifts}), 16'h0);
        check("off_freq", 16'(c1_freq), 16'h0);
        check("off_nr12", 16'({c1_vol, c1_env_inc, c1_env_n, c1_dac}), 16'h0);
        bus_write(3'd4, 8'h80);
        check("off_no_start", 16'({c1_start, c1_single}), 16'h0);
        freq_wb_valid = 1'b1; freq_wb = 11'h3C3;
        tick();
        freq_wb_valid = 1'b0;
        check("off_wb_ignored", 16'(c1_freq), 16'h0);
        bus_read(3'd1);
        check("off_read", 16'(c1_rdata), 16'h3F);

        // Reset overrides a simultaneous write
        apu_enable = 1'b1;
        reset = 1'b1;
        bus_write(3'd1, 8'hFF);
        reset = 1'b0;
        check("rst_over_wr", 16'({c1_duty, c1_length}), 16'h0);

        bus_write(3'd0, 8'h7F);
        check("ch2_nr10_ign", 16'({c2_sweep_time, c2_sweep_dec, c2_shifts}), 16'h0);
        check("ch1_nr10", 16'({c1_sweep_time, c1_sweep_dec, c1_shifts}), 16'h7F);
        bus_read(3'd0);
        check("rd_ch2_nr10", 16'(c2_rdata), 16'hFF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
